icache_line_ram: RTL and testbench

Parametrised single-clock simple-dual-port line RAM for the icache data and tag arrays. One read port returns a full cache line. One write port updates any subset of the line's banks through a per-bank mask. After reset, a built-in clear engine zeroes every entry, and an `init_done` flag gates normal traffic. Reads that hit the same-cycle write address are forwarded (write-first), so the icache FSM can refill a line and read it back without a stall.

---
 rtl/icache_pkg.sv | 12 +
 rtl/icache_line_ram_if.sv | 24 ++
 rtl/bank_sdp_ram.sv | 26 ++
 rtl/icache_line_ram.sv | 91 +++++++++
 tb/tb_icache_line_ram.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared icache geometry, line type and line-RAM state encoding.
package icache_pkg;
   localparam int INDEX_SIZE  = 8;
   localparam int OFFSET_SIZE = 5;
   localparam int TAG_SIZE    = 32 - INDEX_SIZE - OFFSET_SIZE;
   localparam int BANK_NUM    = 8;
   localparam int BANK_SIZE   = 32;
   localparam int SETSIZE     = 2 ** INDEX_SIZE;
   typedef logic [BANK_SIZE-1:0] word_t;
   typedef word_t [BANK_NUM-1:0] line_t;
   typedef enum logic {CLEAR, READY} ram_state_t;
endpackage

// File: rtl/icache_line_ram_if.sv
// icache_line_ram_if: read/write port bundle of the icache line RAM.
interface icache_line_ram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BANK_NUM   = 8,
   parameter int ADDR_WIDTH = 8
) ();
   logic                           init_done;
   logic                           read_en;
   logic [ADDR_WIDTH-1:0]          read_addr;
   logic [DATA_WIDTH*BANK_NUM-1:0] read_data;
   logic                           read_valid;
   logic                           write_en;
   logic [ADDR_WIDTH-1:0]          write_addr;
   logic [BANK_NUM-1:0]            write_mask;
   logic [DATA_WIDTH*BANK_NUM-1:0] write_data;
   modport master (
      output read_en, read_addr, write_en, write_addr, write_mask, write_data,
      input  init_done, read_data, read_valid
   );
   modport slave (
      input  read_en, read_addr, write_en, write_addr, write_mask, write_data,
      output init_done, read_data, read_valid
   );
endinterface

// File: rtl/bank_sdp_ram.sv
// bank_sdp_ram: one simple-dual-port bank, registered read that holds when idle.
module bank_sdp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_write,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   always_ff @(posedge clk_write) begin
      if (we) mem_q[waddr] <= wdata;
   end
   always_comb rdata_d = re ? mem_q[raddr] : rdata_q;
   always_ff @(posedge clk_write) begin
      if (reset) rdata_q <= '0;
      else rdata_q <= rdata_d;
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/icache_line_ram.sv
// icache_line_ram: banked line RAM with post-reset clear engine and write-first forwarding.
module icache_line_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int BANK_NUM   = 8,
   parameter int ADDR_WIDTH = 8,
   parameter bit OUT_REG    = 0
) (
   input logic               clk_write,
   input logic               reset,
   icache_line_ram_if.slave  bus
);
   localparam int LINE_W = DATA_WIDTH * BANK_NUM;
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] CLR_ONE  = (ADDR_WIDTH+1)'(1);
   icache_pkg::ram_state_t state_q, state_d;
   logic [ADDR_WIDTH:0]   clr_idx_q, clr_idx_d;
   logic                  clearing, rd_acc, wr_acc, hit;
   logic [BANK_NUM-1:0]   bank_we, fwd_mask_q, fwd_mask_d;
   logic [ADDR_WIDTH-1:0] bank_waddr;
   logic [LINE_W-1:0]     bank_wdata, bank_rdata, fwd_data_q, fwd_data_d, rd_line;
   logic                  rvalid_q, rvalid_d;
   always_comb begin
      clearing   = !reset && state_q == icache_pkg::CLEAR;
      rd_acc     = !reset && state_q == icache_pkg::READY && bus.read_en;
      wr_acc     = !reset && state_q == icache_pkg::READY && bus.write_en;
      hit        = rd_acc && wr_acc && bus.read_addr == bus.write_addr;
      state_d    = clearing && clr_idx_q == CLR_LAST ? icache_pkg::READY : state_q;
      clr_idx_d  = clearing ? clr_idx_q + CLR_ONE : clr_idx_q;
      bank_we    = clearing ? '1 : wr_acc ? bus.write_mask : '0;
      bank_waddr = clearing ? clr_idx_q[ADDR_WIDTH-1:0] : bus.write_addr;
      bank_wdata = clearing ? '0 : bus.write_data;
      // Forwarding info travels with the read so the bank's old data can be patched next cycle.
      fwd_mask_d = rd_acc ? (hit ? bus.write_mask : '0) : fwd_mask_q;
      fwd_data_d = rd_acc ? bus.write_data : fwd_data_q;
      rvalid_d   = rd_acc;
      rd_line    = bank_rdata;
      for (int b = 0; b < BANK_NUM; b++)
         if (fwd_mask_q[b]) rd_line[b*DATA_WIDTH +: DATA_WIDTH] = fwd_data_q[b*DATA_WIDTH +: DATA_WIDTH];
   end
   always_ff @(posedge clk_write) begin
      if (reset) begin
         state_q    <= icache_pkg::CLEAR;
         clr_idx_q  <= '0;
         fwd_mask_q <= '0;
         fwd_data_q <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         fwd_mask_q <= fwd_mask_d;
         fwd_data_q <= fwd_data_d;
         rvalid_q   <= rvalid_d;
      end
   end
   for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
      bank_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank (
         .clk_write (clk_write),
         .reset     (reset),
         .we        (bank_we[g]),
         .waddr     (bank_waddr),
         .wdata     (bank_wdata[g*DATA_WIDTH +: DATA_WIDTH]),
         .re        (rd_acc),
         .raddr     (bus.read_addr),
         .rdata     (bank_rdata[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end
   if (OUT_REG) begin : g_out_reg
      logic [LINE_W-1:0] out_q, out_d;
      logic              ovalid_q, ovalid_d;
      always_comb begin
         out_d    = rvalid_q ? rd_line : out_q;
         ovalid_d = rvalid_q;
      end
      always_ff @(posedge clk_write) begin
         if (reset) begin
            out_q    <= '0;
            ovalid_q <= 1'b0;
         end else begin
            out_q    <= out_d;
            ovalid_q <= ovalid_d;
         end
      end
      assign bus.read_data  = out_q;
      assign bus.read_valid = ovalid_q;
   end else begin : g_out_direct
      assign bus.read_data  = rd_line;
      assign bus.read_valid = rvalid_q;
   end
   assign bus.init_done = state_q == icache_pkg::READY;
endmodule

// File: tb/tb_icache_line_ram.sv
// tb_icache_line_ram: directed vector table run against latency-1 and latency-2 instances in lockstep.
module tb_icache_line_ram;
   localparam int DW = 32, BN = 8, AW = 8, LW = DW * BN;
   logic clk_write = 1'b0;
   always #5 clk_write = ~clk_write;
   logic reset, read_en, write_en;
   logic [AW-1:0] read_addr, write_addr;
   logic [BN-1:0] write_mask;
   logic [LW-1:0] write_data;
   icache_line_ram_if #(.DATA_WIDTH(DW), .BANK_NUM(BN), .ADDR_WIDTH(AW)) if0 ();
   icache_line_ram_if #(.DATA_WIDTH(DW), .BANK_NUM(BN), .ADDR_WIDTH(AW)) if1 ();
   assign if0.read_en = read_en;       assign if1.read_en = read_en;
   assign if0.read_addr = read_addr;   assign if1.read_addr = read_addr;
   assign if0.write_en = write_en;     assign if1.write_en = write_en;
   assign if0.write_addr = write_addr; assign if1.write_addr = write_addr;
   assign if0.write_mask = write_mask; assign if1.write_mask = write_mask;
   assign if0.write_data = write_data; assign if1.write_data = write_data;
   icache_line_ram #(.DATA_WIDTH(DW), .BANK_NUM(BN), .ADDR_WIDTH(AW), .OUT_REG(0)) u_dut0 (
      .clk_write (clk_write), .reset (reset), .bus (if0));
   icache_line_ram #(.DATA_WIDTH(DW), .BANK_NUM(BN), .ADDR_WIDTH(AW), .OUT_REG(1)) u_dut1 (
      .clk_write (clk_write), .reset (reset), .bus (if1));
   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [BN-1:0] mask;
      logic [LW-1:0] wd;
      logic          re;
      logic [AW-1:0] ra;
      logic          ev;
      logic [LW-1:0] ed;
   } vec_t;
   vec_t vec [13];
   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk_write);
      #1;
   endtask
   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [BN-1:0] mask,
                        input logic [LW-1:0] wd, input logic re, input logic [AW-1:0] ra);
      write_en = we; write_addr = wa; write_mask = mask; write_data = wd;
      read_en = re; read_addr = ra;
   endtask
   function automatic logic [LW-1:0] line_a();
      logic [LW-1:0] l;
      for (int b = 0; b < BN; b++) l[b*DW +: DW] = 32'hA000_0000 + 32'(b);
      return l;
   endfunction
   // Counts edges after release until init_done; pokes write/read of 0x55 at edge 10 of the clear.
   task automatic wait_init(input string nm);
      int e0 = 0, e1 = 0;
      logic seen = 1'b0;
      for (int k = 1; k <= 400 && (e0 == 0 || e1 == 0); k++) begin
         if (k == 10) drive(1'b1, 8'h55, 8'hFF, '1, 1'b1, 8'h55);
         else if (k == 11) drive(1'b0, 8'h00, 8'h00, '0, 1'b0, 8'h00);
         step;
         seen |= if0.read_valid | if1.read_valid;
         if (e0 == 0 && if0.init_done) e0 = k;
         if (e1 == 0 && if1.init_done) e1 = k;
      end
      chk({nm, " init_done edge lat1"}, LW'(e0), LW'(256));
      chk({nm, " init_done edge lat2"}, LW'(e1), LW'(256));
      chk({nm, " no read_valid in clear"}, LW'(seen), LW'(0));
   endtask
   initial begin
      logic [LW-1:0] la, lp, mix;
      la  = line_a();
      lp  = la;
      lp[0*DW +: DW] = 32'hFFFF_FFFF;
      lp[2*DW +: DW] = 32'hFFFF_FFFF;
      mix = {{4{32'h1111_1111}}, {4{32'h2222_2222}}};
      vec[0]  = '{1'b0, 8'h00, 8'h00, '0,              1'b1, 8'h00, 1'b1, '0};
      vec[1]  = '{1'b0, 8'h00, 8'h00, '0,              1'b1, 8'h7F, 1'b1, '0};
      vec[2]  = '{1'b0, 8'h00, 8'h00, '0,              1'b1, 8'hFF, 1'b1, '0};
      vec[3]  = '{1'b1, 8'h12, 8'hFF, la,              1'b0, 8'h00, 1'b0, '0};
      vec[4]  = '{1'b0, 8'h00, 8'h00, '0,              1'b1, 8'h12, 1'b1, la};
      vec[5]  = '{1'b1, 8'h12, 8'h05, '1,              1'b0, 8'h00, 1'b0, '0};
      vec[6]  = '{1'b0, 8'h00, 8'h00, '0,              1'b1, 8'h12, 1'b1, lp};
      vec[7]  = '{1'b1, 8'h34, 8'hFF, {8{32'h1111_1111}}, 1'b0, 8'h00, 1'b0, '0};
      vec[8]  = '{1'b1, 8'h34, 8'h0F, {8{32'h2222_2222}}, 1'b1, 8'h34, 1'b1, mix};
      vec[9]  = '{1'b0, 8'h00, 8'h00, '0,              1'b1, 8'h34, 1'b1, mix};
      vec[10] = '{1'b1, 8'h34, 8'h00, {8{32'h3333_3333}}, 1'b1, 8'h55, 1'b1, '0};
      vec[11] = '{1'b0, 8'h00, 8'h00, '0,              1'b1, 8'h34, 1'b1, mix};
      vec[12] = '{1'b0, 8'h00, 8'h00, '0,              1'b0, 8'h00, 1'b0, '0};
      drive(1'b0, 8'h00, 8'h00, '0, 1'b0, 8'h00);
      reset = 1'b1;
      repeat (3) step;
      chk("reset init_done lat1", LW'(if0.init_done), LW'(0));
      chk("reset init_done lat2", LW'(if1.init_done), LW'(0));
      chk("reset read_valid lat1", LW'(if0.read_valid), LW'(0));
      chk("reset read_data lat1", if0.read_data, '0);
      chk("reset read_data lat2", if1.read_data, '0);
      reset = 1'b0;
      wait_init("boot");
      for (int i = 0; i < 13; i++) begin
         drive(vec[i].we, vec[i].wa, vec[i].mask, vec[i].wd, vec[i].re, vec[i].ra);
         step;
         chk($sformatf("vec%0d valid lat1", i), LW'(if0.read_valid), LW'(vec[i].ev));
         if (vec[i].ev) chk($sformatf("vec%0d data lat1", i), if0.read_data, vec[i].ed);
         if (i > 0) begin
            chk($sformatf("vec%0d valid lat2", i-1), LW'(if1.read_valid), LW'(vec[i-1].ev));
            if (vec[i-1].ev) chk($sformatf("vec%0d data lat2", i-1), if1.read_data, vec[i-1].ed);
         end
      end
      drive(1'b0, 8'h00, 8'h00, '0, 1'b0, 8'h00);
      step;
      chk("vec12 valid lat2", LW'(if1.read_valid), LW'(0));
      drive(1'b0, 8'h00, 8'h00, '0, 1'b1, 8'h12);
      step;
      step;
      chk("stream valid lat1", LW'(if0.read_valid), LW'(1));
      chk("stream data lat1", if0.read_data, lp);
      chk("stream valid lat2", LW'(if1.read_valid), LW'(1));
      reset = 1'b1;
      step;
      chk("mid-stream rst valid lat1", LW'(if0.read_valid), LW'(0));
      chk("mid-stream rst valid lat2", LW'(if1.read_valid), LW'(0));
      chk("mid-stream rst init_done", LW'(if0.init_done), LW'(0));
      chk("mid-stream rst data lat1", if0.read_data, '0);
      chk("mid-stream rst data lat2", if1.read_data, '0);
      reset = 1'b0;
      drive(1'b0, 8'h00, 8'h00, '0, 1'b0, 8'h00);
      wait_init("mid-stream rst");
      drive(1'b0, 8'h00, 8'h00, '0, 1'b1, 8'h12);
      step;
      drive(1'b0, 8'h00, 8'h00, '0, 1'b0, 8'h00);
      chk("recleared valid lat1", LW'(if0.read_valid), LW'(1));
      chk("recleared data lat1", if0.read_data, '0);
      step;
      chk("recleared valid lat2", LW'(if1.read_valid), LW'(1));
      chk("recleared data lat2", if1.read_data, '0);
      reset = 1'b1;
      step;
      reset = 1'b0;
      repeat (100) step;
      reset = 1'b1;
      step;
      chk("clear abort init_done lat1", LW'(if0.init_done), LW'(0));
      chk("clear abort init_done lat2", LW'(if1.init_done), LW'(0));
      reset = 1'b0;
      wait_init("clear abort");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
